config_writer: RTL

Host-side initiator for the backend cycle controller's configuration port. It accepts 16- or 32-bit register writes from a valid/ready host stream, splits 32-bit writes into low-then-high half-word strobes, and drives the active-low `write_config_n` / `config_address` / `config_data` bus with enforced inter-write gaps. It also owns the controller's `timer_enable`: it drops the enable around timing-register writes so each reprogrammed cycle restarts cleanly. It sits between the host/register-bank logic and one backend cycle controller instance.

---
 rtl/config_writer_pkg.sv | 36 +++
 rtl/config_shadow_file.sv | 48 ++++
 rtl/config_writer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/config_writer_pkg.sv
// Shared types and register map for the config_writer host-side initiator.
package config_writer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WRITE_LO,
      WRITE_HI,
      GAP
   } state_e;

   localparam logic [5:0] ADDR_CCR0_LO     = 6'h00;
   localparam logic [5:0] ADDR_CCR0_HI     = 6'h01;
   localparam logic [5:0] ADDR_CCR1_LO     = 6'h02;
   localparam logic [5:0] ADDR_CCR1_HI     = 6'h03;
   localparam logic [5:0] ADDR_ORDER_LO    = 6'h04;
   localparam logic [5:0] ADDR_ORDER_HI    = 6'h05;
   localparam logic [5:0] ADDR_LIMIT_LO    = 6'h06;
   localparam logic [5:0] ADDR_LIMIT_HI    = 6'h07;
   localparam logic [5:0] ADDR_MODE        = 6'h08;
   localparam logic [5:0] ADDR_ROW_COL_SEL = 6'h09;

   localparam logic [5:0] ADDR_LAST_TIMING = 6'h07;
   localparam logic [5:0] ADDR_LAST_WIDE   = 6'h04;

   // Wide writes must target the low half of an aligned pair below the limit registers.
   function automatic logic cmd_is_legal(input logic [5:0] addr, input logic wide,
                                         input int num_regs);
      logic legal;
      legal = (int'(addr) < num_regs);
      if (wide && (addr[0] || (addr > ADDR_LAST_WIDE))) begin
         legal = 1'b0;
      end
      return legal;
   endfunction

endpackage

// File: rtl/config_shadow_file.sv
// Shadow copy of every register written to the controller, with a registered readback port.
module config_shadow_file
   import config_writer_pkg::*;
#(
   parameter int NUM_REGS = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        write_en_i,
   input  logic [5:0]  write_addr_i,
   input  logic [15:0] write_data_i,
   input  logic [5:0]  read_addr_i,
   output logic [15:0] read_data_o
);

   logic [15:0] mem_q [NUM_REGS];
   logic [15:0] read_data_q;
   logic [15:0] read_data_d;

   // Out-of-range read addresses simply match no entry and return zero.
   always_comb begin
      read_data_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (read_addr_i == 6'(i)) begin
            read_data_d = mem_q[i];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
         read_data_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (write_en_i && (write_addr_i == 6'(i))) begin
               mem_q[i] <= write_data_i;
            end
         end
         read_data_q <= read_data_d;
      end
   end

   assign read_data_o = read_data_q;

endmodule

// File: rtl/config_writer.sv
// Drives the cycle controller's config bus from a host valid/ready stream and gates its timer.
// Optional shadow readback is enabled by defining CONFIG_WRITER_READBACK_EN.
module config_writer
   import config_writer_pkg::*;
#(
   parameter int WRITE_GAP = 1,
   parameter int NUM_REGS  = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        host_valid,
   output logic        host_ready,
   input  logic [5:0]  host_address,
   input  logic        host_wide,
   input  logic [31:0] host_data,
   input  logic        run_request,
   input  logic        clear_error,
   output logic        write_config_n,
   output logic [5:0]  config_address,
   output logic [15:0] config_data,
   output logic        timer_enable,
   output logic        busy,
   output logic        cmd_error,
`ifdef CONFIG_WRITER_READBACK_EN
   input  logic [5:0]  rb_address,
   output logic [15:0] rb_data,
`endif
   output logic [15:0] write_count
);

   localparam logic [3:0] GAP_INIT = 4'(WRITE_GAP - 1);

   state_e      state_q, state_d;
   logic [5:0]  cmd_addr_q, cmd_addr_d;
   logic [31:0] cmd_data_q, cmd_data_d;
   logic        cmd_wide_q, cmd_wide_d;
   logic        gate_q, gate_d;
   logic [3:0]  gap_cnt_q, gap_cnt_d;
   logic        error_q, error_d;
   logic        ready_q;
   logic        strobe_n_q;
   logic        strobe_d;
   logic [5:0]  cfg_addr_q, cfg_addr_d;
   logic [15:0] cfg_data_q, cfg_data_d;
   logic        timer_en_q, timer_en_d;
   logic        busy_q;
   logic [15:0] count_q;
   logic        accept;
   logic        legal;

   assign accept = host_valid && ready_q;
   assign legal  = cmd_is_legal(host_address, host_wide, NUM_REGS);

   // Next-state logic; bus outputs are derived from the next state so they are registered.
   always_comb begin
      state_d    = state_q;
      cmd_addr_d = cmd_addr_q;
      cmd_data_d = cmd_data_q;
      cmd_wide_d = cmd_wide_q;
      gate_d     = gate_q;
      gap_cnt_d  = gap_cnt_q;
      error_d    = error_q;
      strobe_d   = 1'b0;
      cfg_addr_d = cfg_addr_q;
      cfg_data_d = cfg_data_q;

      if (clear_error) begin
         error_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (legal) begin
                  cmd_addr_d = host_address;
                  cmd_data_d = host_data;
                  cmd_wide_d = host_wide;
                  gate_d     = (host_address <= ADDR_LAST_TIMING);
                  state_d    = WRITE_LO;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         WRITE_LO: begin
            state_d   = cmd_wide_q ? WRITE_HI : GAP;
            gap_cnt_d = GAP_INIT;
         end
         WRITE_HI: begin
            state_d   = GAP;
            gap_cnt_d = GAP_INIT;
         end
         GAP: begin
            if (gap_cnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         WRITE_LO: begin
            strobe_d   = 1'b1;
            cfg_addr_d = cmd_addr_d;
            cfg_data_d = cmd_data_d[15:0];
         end
         WRITE_HI: begin
            strobe_d   = 1'b1;
            cfg_addr_d = cmd_addr_d + 6'd1;
            cfg_data_d = cmd_data_d[31:16];
         end
         default: ;
      endcase

      timer_en_d = ((state_d != IDLE) && gate_d) ? 1'b0 : run_request;
   end

   // State and output registers; a reset mid-command abandons any pending strobe.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         cmd_addr_q <= '0;
         cmd_data_q <= '0;
         cmd_wide_q <= 1'b0;
         gate_q     <= 1'b0;
         gap_cnt_q  <= '0;
         error_q    <= 1'b0;
         ready_q    <= 1'b0;
         strobe_n_q <= 1'b1;
         cfg_addr_q <= '0;
         cfg_data_q <= '0;
         timer_en_q <= 1'b0;
         busy_q     <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         cmd_addr_q <= cmd_addr_d;
         cmd_data_q <= cmd_data_d;
         cmd_wide_q <= cmd_wide_d;
         gate_q     <= gate_d;
         gap_cnt_q  <= gap_cnt_d;
         error_q    <= error_d;
         ready_q    <= (state_d == IDLE);
         strobe_n_q <= ~strobe_d;
         cfg_addr_q <= cfg_addr_d;
         cfg_data_q <= cfg_data_d;
         timer_en_q <= timer_en_d;
         busy_q     <= (state_d != IDLE);
         if (!strobe_n_q) begin
            count_q <= count_q + 16'd1;
         end
      end
   end

   assign host_ready     = ready_q;
   assign write_config_n = strobe_n_q;
   assign config_address = cfg_addr_q;
   assign config_data    = cfg_data_q;
   assign timer_enable   = timer_en_q;
   assign busy           = busy_q;
   assign cmd_error      = error_q;
   assign write_count    = count_q;

`ifdef CONFIG_WRITER_READBACK_EN
   config_shadow_file #(
      .NUM_REGS(NUM_REGS)
   ) u_shadow (
      .clock       (clock),
      .reset       (reset),
      .write_en_i  (strobe_d),
      .write_addr_i(cfg_addr_d),
      .write_data_i(cfg_data_d),
      .read_addr_i (rb_address),
      .read_data_o (rb_data)
   );
`endif

endmodule
